// File: rtl/convertidor_inverso.sv
// convertidor_inverso: maps a 10-bit scaled value x back to the 8-bit domain,
// q = floor(2*x/5), using a sequential restoring divide-by-5 that produces one
// quotient bit per clock behind a start/busy/done handshake.
// Optional build macro CONVERTIDOR_INVERSO_ROUND_EN: round to nearest by
// dividing 2*x+2 instead of 2*x (saturation then begins at x = 639).
//
// state | meaning
// IDLE  | waiting for start, outputs hold the last result
// DIV   | one restoring-division step per clock, dividend MSB first
// FIN   | publish result (or saturate), pulse done, back to IDLE
module convertidor_inverso #(
  parameter int ITER = 12  // dividend width; only 12 is supported
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] datoEntrada,
  output logic       busy,
  output logic       done,
  output logic [7:0] datoSalida,
  output logic [2:0] resto,
  output logic       sat
);

  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t      state, state_next;
  logic [11:0] dividend;
  logic [11:0] quotient;
  logic [2:0]  rem;
  logic [3:0]  cnt;

  logic [11:0] dividend_load;
  logic [3:0]  trial;
  logic        qbit;
  logic [2:0]  rem_next;
  logic        accept;

`ifdef CONVERTIDOR_INVERSO_ROUND_EN
  // +2 on the doubled value is +0.5 on the quotient; 2x+2 never hits x.5 ties
  assign dividend_load = {1'b0, datoEntrada, 1'b0} + 12'd2;
`else
  assign dividend_load = {1'b0, datoEntrada, 1'b0};
`endif

  assign accept = (state == IDLE) && start;

  // restoring step: remainder is always < 5, so trial never exceeds 9
  always_comb begin
    trial    = {rem, dividend[11]};
    qbit     = (trial >= 4'd5);
    rem_next = trial[2:0];
    if (qbit) rem_next = 3'(trial - 4'd5);
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIV;
      DIV:     if (cnt == 4'd0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // division datapath: load on accepted start, shift one bit per DIV cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dividend <= '0;
      quotient <= '0;
      rem      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      dividend <= dividend_load;
      quotient <= '0;
      rem      <= '0;
      cnt      <= 4'(ITER - 1);
    end else if (state == DIV) begin
      dividend <= {dividend[10:0], 1'b0};
      quotient <= {quotient[10:0], qbit};
      rem      <= rem_next;
      if (cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // handshake and result registers; results hold between conversions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      datoSalida <= '0;
      resto      <= '0;
      sat        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) busy <= 1'b1;
      if (state == FIN) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (|quotient[11:8]) begin
          datoSalida <= 8'hFF;
          resto      <= 3'd0;
          sat        <= 1'b1;
        end else begin
          datoSalida <= quotient[7:0];
          resto      <= rem;
          sat        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_convertidor_inverso.sv
// Self-checking bench for convertidor_inverso: directed boundary values plus
// random values against an arithmetic reference (plain / and %).
module tb_convertidor_inverso;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] datoEntrada;
  logic       busy;
  logic       done;
  logic [7:0] datoSalida;
  logic [2:0] resto;
  logic       sat;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q = 0, exp_r = 0;
  bit exp_s = 0;

  convertidor_inverso dut (
    .clk(clk), .reset(reset), .start(start), .datoEntrada(datoEntrada),
    .busy(busy), .done(done), .datoSalida(datoSalida), .resto(resto), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int x, output int q, output int r, output bit s);
    int d;
    d = 2 * x;
`ifdef CONVERTIDOR_INVERSO_ROUND_EN
    d = d + 2;
`endif
    q = d / 5;
    r = d % 5;
    s = 1'b0;
    if (q > 255) begin
      q = 255;
      r = 0;
      s = 1'b1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full conversion; optionally pulse start (x=5) so it is sampled at E3 and E7
  task automatic convert(input int x, input bit inject);
    start = 1'b1;
    datoEntrada = 10'(x);
    tick();  // E0
    start = 1'b0;
    datoEntrada = 10'($urandom);
    check($sformatf("busy_done_E0 x=%0d", x), {busy, done}, 2'b10);
    for (int k = 1; k <= 12; k++) begin
      if (inject && (k == 3 || k == 7)) begin
        start = 1'b1;
        datoEntrada = 10'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      check($sformatf("busy_done_E%0d x=%0d", k, x), {busy, done}, 2'b10);
    end
    start = 1'b0;
    tick();  // E13
    model(x, exp_q, exp_r, exp_s);
    check($sformatf("busy_done_E13 x=%0d", x), {busy, done}, 2'b01);
    check($sformatf("datoSalida x=%0d", x), datoSalida, exp_q);
    check($sformatf("resto x=%0d", x), resto, exp_r);
    check($sformatf("sat x=%0d", x), sat, exp_s);
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_busy_done", {busy, done}, 2'b00);
      check("idle_hold", {sat, resto, datoSalida}, {exp_s, 3'(exp_r), 8'(exp_q)});
    end
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    start = 1'b0;
    datoEntrada = '0;
    #12;
    reset = 1'b0;

    // reset state and no spurious done
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_idle", {busy, done, sat, resto, datoSalida}, 0);
    end

    // directed boundaries, back-to-back (next start sampled the edge after done)
    convert(100, 0);
    convert(102, 0);
    convert(637, 0);
    convert(639, 0);
    convert(640, 0);
    convert(1023, 0);
    convert(101, 0);
    convert(0, 0);
    convert(638, 0);
    idle_hold(3);

    // starts during busy are ignored and not queued
    convert(200, 1);
    check("ignored_start_result", datoSalida, 80);
    idle_hold(2);
    convert(5, 0);
    check("second_start_result", datoSalida, 2);
    idle_hold(1);

    // asynchronous reset mid-conversion
    start = 1'b1;
    datoEntrada = 10'd500;
    tick();
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_clear", {busy, done, sat, resto, datoSalida}, 0);
    tick();
    tick();
    #3;
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      dones += int'(done);
    end
    check("no_done_after_reset", dones, 0);
    check("cleared_after_reset", {busy, sat, resto, datoSalida}, 0);
    convert(500, 0);

    // random values with random idle gaps
    for (int i = 0; i < 20; i++) begin
      convert(int'($urandom_range(0, 1023)), 0);
      idle_hold(int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/convertidor_inverso.md
Name: convertidor_inverso

Overview:
- Inverse of the 5/2 scaling converter: maps a 10-bit scaled value back to the 8-bit domain, q = floor(2·x/5).
- Used where a display/threshold value in scaled units must be compared against or written back as an 8-bit raw value.
- Sequential restoring divider (divide by constant 5, one quotient bit per clock) with a start/busy/done handshake, in place of a combinational divider.

Parameters:
- ITER, 12, number of division iterations. Equals the dividend width. Fixed; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- datoEntrada  input  10  scaled value x, 0..1023
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the result is valid
- datoSalida  output  8  result q, held until the next done
- resto  output  3  remainder of (dividend mod 5); 0 when saturated
- sat  output  1  high when true quotient > 255; held with datoSalida

Behaviour:
- Reset, asynchronous active-high:
  - State = IDLE.
  - busy=0, done=0, datoSalida=0, resto=0, sat=0.
  - Internal dividend, partial remainder and bit counter all cleared.
- States: IDLE -> DIV -> FIN -> IDLE.
- IDLE:
  - On a clock edge with start=1, load dividend D = 2·datoEntrada (12 bits, zero-extended).
  - Clear the partial remainder R (3 bits) and set the counter to ITER-1.
  - Go to DIV; busy=1 from the next cycle.
- DIV, one iteration per edge, MSB of D first:
  - T = {R, next D bit}.
  - If T >= 5: R = T-5 and quotient bit = 1; else R = T and quotient bit = 0.
  - Shift the quotient bit into a 12-bit quotient register Q.
  - After ITER iterations (counter reaches 0), go to FIN.
- FIN, one edge:
  - If Q > 255: datoSalida=255, sat=1, resto=0.
  - Else: datoSalida=Q[7:0], sat=0, resto=R.
  - done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency:
  - Start sampled at edge E0.
  - DIV occupies E1..E12.
  - Outputs update and done rises at E13, for 13 cycles total.
  - busy is high from after E0 until E13.
  - A new start may be sampled on the edge after done (back-to-back every 14 cycles).
- start while busy: ignored. It is not queued and datoEntrada is not resampled.
- datoEntrada may change freely after the E0 sample.
- Outputs hold their last result between conversions; done is low except in the FIN cycle.
- Saturation boundary: x ≤ 639 gives a non-saturated result; x ≥ 640 gives sat=1.
- Reset asserted mid-conversion:
  - Immediate return to IDLE with all outputs cleared.
  - No done pulse.
  - The next start after reset deassertion behaves normally.

Optional Feature:
- Macro: CONVERTIDOR_INVERSO_ROUND_EN
- Defined: round to nearest.
  - Dividend D = 2·x + 2, which equals floor(2x/5 + 0.5). Ties cannot occur.
  - Saturation boundary moves to x ≥ 639.
  - resto is the remainder of (2x+2) mod 5.
  - Latency unchanged (13 cycles).
- Undefined: truncation, D = 2·x, as described in Behaviour.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, datoSalida=0, resto=0, sat=0; no spurious done.
- start with x=100 at E0 -> done exactly at E13; datoSalida=40, resto=0, sat=0; busy high for E1..E12.
- Truncation mode:
  - x=102 -> 40, resto=4.
  - x=637 -> 254, resto=4.
  - x=639 -> 255, sat=0.
  - x=640 -> 255, sat=1, resto=0.
  - x=1023 -> 255, sat=1.
- ROUND_EN defined:
  - x=101 -> 40.
  - x=102 -> 41, resto=1.
  - x=637 -> 255, sat=0.
  - x=639 -> 255, sat=1.
- x=200 started, then start pulses with x=5 at E3 and E7 -> single done at E13 with result 80; second start accepted only after done, giving 2.
- Reset asserted asynchronously at E6 of a conversion with x=500 -> outputs clear immediately, no done pulse; a fresh start with x=500 gives 200 after 13 cycles.
